// File: rtl/matvec_pkg.sv
// matvec_pkg: shared FSM state type and accumulator width helper for matvec_param
package matvec_pkg;
  typedef enum logic [1:0] {IDLE, LOAD_M, LOAD_V, COMPUTE} state_t;
  function automatic int acc_width(input int iw, input int k);
    return 2 * iw + $clog2(k);
  endfunction
endpackage

// File: rtl/matvec_out_fifo.sv
// matvec_out_fifo: result buffer with push-while-full allowed when a pop happens on the same edge
module matvec_out_fifo #(
  parameter int OW = 28,
  parameter int ODEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [OW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [OW-1:0] dout
);
  localparam int PW = ODEPTH > 1 ? $clog2(ODEPTH) : 1;
  localparam int CW = $clog2(ODEPTH + 1);
  logic [OW-1:0] mem_q [1 << PW];
  logic [OW-1:0] mem_d [1 << PW];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == CW'(ODEPTH);
  assign empty = cnt_q == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem_q[rd_q];
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d = !do_push ? wr_q : wr_q == PW'(ODEPTH - 1) ? '0 : wr_q + 1'b1;
    rd_d = !do_pop ? rd_q : rd_q == PW'(ODEPTH - 1) ? '0 : rd_q + 1'b1;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/matvec_param.sv
// matvec_param: streaming K x K matrix times K-vector with stored matrix reuse and buffered results
module matvec_param
  import matvec_pkg::*;
#(
  parameter int K = 8,
  parameter int IW = 14,
  parameter int OW = 28,
  parameter int SAT = 0,
  parameter int ODEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          input_valid,
  output logic          input_ready,
  input  logic [IW-1:0] input_data,
  input  logic          new_matrix,
  output logic          output_valid,
  input  logic          output_ready,
  output logic [OW-1:0] output_data
);
  localparam int AW = acc_width(IW, K);
  localparam int MW = $clog2(K * K);
  localparam int VW = $clog2(K);
  localparam int EW = (AW > OW ? AW : OW) + 1;
  localparam logic signed [EW-1:0] HI = {{(EW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [EW-1:0] LO = {{(EW - OW + 1){1'b1}}, {(OW - 1){1'b0}}};
  state_t state_q, state_d;
  logic [MW-1:0] mi_q, mi_d;
  logic [VW-1:0] vi_q, vi_d, row_q, row_d;
  logic push_q, push_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [IW-1:0] m_q [K * K];
  logic signed [IW-1:0] m_d [K * K];
  logic signed [IW-1:0] x_q [K];
  logic signed [IW-1:0] x_d [K];
  logic signed [2*IW-1:0] prod;
  logic signed [EW-1:0] acc_x;
  logic [OW-1:0] y;
  logic accept, pop, fifo_push, fifo_full, fifo_empty;
  logic mat_last, vec_last, row_last;
  assign input_ready = state_q != COMPUTE;
  assign accept = input_valid && input_ready;
  assign output_valid = !fifo_empty;
  assign pop = output_valid && output_ready;
  assign fifo_push = state_q == COMPUTE && push_q && (!fifo_full || pop);
  assign mat_last = mi_q == MW'(K * K - 1);
  assign vec_last = vi_q == VW'(K - 1);
  assign row_last = row_q == VW'(K - 1);
  assign prod = m_q[mi_q] * x_q[vi_q];
  assign acc_x = EW'(acc_q);
  assign y = (SAT != 0 && acc_x > HI) ? HI[OW-1:0] : (SAT != 0 && acc_x < LO) ? LO[OW-1:0] : acc_x[OW-1:0];
  always_comb begin
    state_d = state_q;
    mi_d = mi_q;
    vi_d = vi_q;
    row_d = row_q;
    push_d = push_q;
    acc_d = acc_q;
    m_d = m_q;
    x_d = x_q;
    case (state_q)
      IDLE: if (accept) begin
        if (new_matrix) begin
          m_d[mi_q] = input_data;
          mi_d = mi_q + 1'b1;
          state_d = LOAD_M;
        end else begin
          x_d[vi_q] = input_data;
          vi_d = vi_q + 1'b1;
          state_d = LOAD_V;
        end
      end
      LOAD_M: if (accept) begin
        m_d[mi_q] = input_data;
        mi_d = mat_last ? '0 : mi_q + 1'b1;
        state_d = mat_last ? LOAD_V : LOAD_M;
      end
      LOAD_V: if (accept) begin
        x_d[vi_q] = input_data;
        vi_d = vec_last ? '0 : vi_q + 1'b1;
        state_d = vec_last ? COMPUTE : LOAD_V;
      end
      COMPUTE: if (!push_q) begin
        acc_d = acc_q + AW'(prod);
        mi_d = mat_last ? '0 : mi_q + 1'b1;
        vi_d = vec_last ? '0 : vi_q + 1'b1;
        push_d = vec_last;
      end else if (fifo_push) begin
        acc_d = '0;
        push_d = 1'b0;
        row_d = row_last ? '0 : row_q + 1'b1;
        mi_d = row_last ? '0 : mi_q;
        state_d = row_last ? IDLE : COMPUTE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mi_q <= '0;
      vi_q <= '0;
      row_q <= '0;
      push_q <= 1'b0;
      acc_q <= '0;
      m_q <= '{default: '0};
      x_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      mi_q <= mi_d;
      vi_q <= vi_d;
      row_q <= row_d;
      push_q <= push_d;
      acc_q <= acc_d;
      m_q <= m_d;
      x_q <= x_d;
    end
  end
  matvec_out_fifo #(.OW(OW), .ODEPTH(ODEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(fifo_push),
    .pop(output_ready),
    .din(y),
    .full(fifo_full),
    .empty(fifo_empty),
    .dout(output_data)
  );
endmodule

// File: tb/tb_matvec_param.sv
// tb_matvec_param: scoreboard bench for matvec_param, wrapping (ODEPTH=4) and saturating instances
module tb_matvec_param;
  localparam int K = 8;
  localparam int IW = 14;
  localparam int OW = 28;
  logic clk = 1'b0;
  logic reset;
  logic iv [2];
  logic ir [2];
  logic nm [2];
  logic ov [2];
  logic ordy [2];
  logic [IW-1:0] id [2];
  logic [OW-1:0] od [2];
  logic [OW-1:0] q0 [$];
  logic [OW-1:0] q1 [$];
  int jm [K * K];
  int jx [K];
  int gm [K * K];
  int n_cmp = 0;
  int n_bad = 0;
  bit rnd = 0;
  bit rnd_rdy = 0;
  always #5 clk = ~clk;
  matvec_param #(.K(K), .IW(IW), .OW(OW), .SAT(0), .ODEPTH(4)) u_wrap (
    .clk(clk), .reset(reset), .input_valid(iv[0]), .input_ready(ir[0]), .input_data(id[0]),
    .new_matrix(nm[0]), .output_valid(ov[0]), .output_ready(ordy[0]), .output_data(od[0])
  );
  matvec_param #(.K(K), .IW(IW), .OW(OW), .SAT(1), .ODEPTH(8)) u_sat (
    .clk(clk), .reset(reset), .input_valid(iv[1]), .input_ready(ir[1]), .input_data(id[1]),
    .new_matrix(nm[1]), .output_valid(ov[1]), .output_ready(ordy[1]), .output_data(od[1])
  );
  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && ov[0] && ordy[0]) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL u_wrap extra output: got %0d expected none", od[0]);
      end else check("u_wrap y", od[0], q0.pop_front());
    end
  end
  always @(negedge clk) begin
    if (!reset && ov[1] && ordy[1]) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL u_sat extra output: got %0d expected none", od[1]);
      end else check("u_sat y", od[1], q1.pop_front());
    end
  end
  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      ordy[0] = 1'($urandom_range(0, 1));
    end
  end
  task automatic send(input int d, input int w, input bit n);
    int t = 0;
    if (rnd && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) begin
      @(posedge clk);
      #1;
    end
    iv[d] = 1'b1;
    id[d] = IW'(w);
    nm[d] = n;
    @(negedge clk);
    while (!ir[d]) begin
      if (++t > 3000) begin
        $display("FAIL input handshake timeout: got ready=0 expected ready=1");
        $fatal(1, "input timeout");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    id[d] = 'x;
    nm[d] = 1'($urandom_range(0, 1));
  endtask
  task automatic job(input int d, input bit n);
    if (n) for (int i = 0; i < K * K; i++) send(d, jm[i], i == 0 ? 1'b1 : 1'($urandom_range(0, 1)));
    for (int i = 0; i < K; i++) send(d, jx[i], (i == 0 && !n) ? 1'b0 : 1'($urandom_range(0, 1)));
  endtask
  task automatic drain();
    int t = 0;
    while (q0.size() != 0 || q1.size() != 0) begin
      @(posedge clk);
      if (++t > 5000) begin
        $display("FAIL drain timeout: got %0d pending expected 0", q0.size() + q1.size());
        $fatal(1, "drain timeout");
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask
  function automatic logic [OW-1:0] model(input int r);
    longint s = 0;
    for (int c = 0; c < K; c++) s += longint'(gm[r * K + c]) * longint'(jx[c]);
    return OW'(s);
  endfunction
  task automatic identity();
    for (int i = 0; i < K * K; i++) jm[i] = (i / K == i % K) ? 1 : 0;
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0;
      nm[d] = 1'b0;
      id[d] = '0;
      ordy[d] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset input_ready", OW'(ir[0]), 1);
    check("reset output_valid", OW'(ov[0]), 0);
    check("reset output_data", od[0], 0);
    ordy[0] = 1'b1;
    ordy[1] = 1'b1;
    identity();
    for (int i = 0; i < K; i++) jx[i] = i + 1;
    for (int i = 0; i < K; i++) q0.push_back(OW'(i + 1));
    job(0, 1'b1);
    for (int i = 1; i <= K + 1; i++) begin
      @(posedge clk);
      #1;
      if (i == K) check("latency valid low at c+K", OW'(ov[0]), 0);
      if (i == K + 1) check("latency valid high at c+K+1", OW'(ov[0]), 1);
    end
    drain();
    for (int i = 0; i < K; i++) jx[i] = 2;
    for (int i = 0; i < K; i++) q0.push_back(OW'(2));
    job(0, 1'b0);
    check("ready low after 8 vector words", OW'(ir[0]), 0);
    drain();
    for (int i = 0; i < K * K; i++) jm[i] = -8192;
    for (int i = 0; i < K; i++) jx[i] = -8192;
    for (int i = 0; i < K; i++) begin
      q0.push_back(OW'(0));
      q1.push_back(OW'(134217727));
    end
    fork
      job(0, 1'b1);
      job(1, 1'b1);
    join
    drain();
    ordy[0] = 1'b0;
    identity();
    for (int i = 0; i < K; i++) jx[i] = 10 + i;
    for (int i = 0; i < K; i++) q0.push_back(OW'(10 + i));
    job(0, 1'b1);
    repeat (120) @(posedge clk);
    #1;
    check("stall output_valid", OW'(ov[0]), 1);
    check("stall input_ready", OW'(ir[0]), 0);
    check("stall head", od[0], 10);
    ordy[0] = 1'b1;
    drain();
    check("ready after drain", OW'(ir[0]), 1);
    for (int i = 0; i < 30; i++) send(0, 5, i == 0 ? 1'b1 : 1'($urandom_range(0, 1)));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid reset output_valid", OW'(ov[0]), 0);
    check("mid reset input_ready", OW'(ir[0]), 1);
    for (int i = 0; i < K; i++) jx[i] = i + 1;
    for (int i = 0; i < K; i++) q0.push_back(OW'(0));
    job(0, 1'b0);
    drain();
    for (int i = 0; i < K * K; i++) gm[i] = 0;
    rnd = 1;
    rnd_rdy = 1;
    for (int j = 0; j < 150; j++) begin
      bit n = (j == 0) || ($urandom_range(0, 2) == 0);
      if (n) for (int i = 0; i < K * K; i++) begin
        jm[i] = int'($urandom_range(0, 16383)) - 8192;
        gm[i] = jm[i];
      end
      for (int i = 0; i < K; i++) jx[i] = int'($urandom_range(0, 16383)) - 8192;
      for (int r = 0; r < K; r++) q0.push_back(model(r));
      job(0, n);
    end
    rnd_rdy = 0;
    @(posedge clk);
    #2;
    ordy[0] = 1'b1;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
